// File: rtl/heater_tx_pkg.sv
// Shared definitions for the heater covert-channel transmitter.
//   - state_t       : transmitter FSM states
//   - MSG_W_DEF     : default message width
//   - CNT_W_DEF     : default period counter width
//   - MIN_PERIOD    : smallest effective SEND window
//   - clamp_period  : raises a requested period to MIN_PERIOD
// Optional build macro: HEATER_TX_MANCHESTER_EN.
// With the macro defined, each bit window is split into two halves, so a
// window needs at least 2 cycles.
package heater_tx_pkg;

  localparam int unsigned MSG_W_DEF = 32;
  localparam int unsigned CNT_W_DEF = 32;

`ifdef HEATER_TX_MANCHESTER_EN
  localparam int unsigned MIN_PERIOD = 2;
`else
  localparam int unsigned MIN_PERIOD = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GUARD,
    DONE
  } state_t;

  // Periods up to 64 bits wide are supported.
  function automatic logic [63:0] clamp_period(input logic [63:0] p);
    return (p < 64'(MIN_PERIOD)) ? 64'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/heater_tx_modulator_if.sv
// Message handshake bundle for heater_tx_modulator.
//   msg_valid/msg_ready : valid/ready handshake
//   msg_data            : payload, bit 0 is sent first
//   msg_len             : number of bits to send
//   bit_period          : heating-window cycles per bit
//   guard_period        : heater-off cycles after each bit
// master = message source, slave = modulator.
interface heater_tx_modulator_if #(
  parameter int unsigned MSG_W = heater_tx_pkg::MSG_W_DEF,
  parameter int unsigned CNT_W = heater_tx_pkg::CNT_W_DEF,
  parameter int unsigned LEN_W = 6
);
  logic             msg_valid;
  logic             msg_ready;
  logic [MSG_W-1:0] msg_data;
  logic [LEN_W-1:0] msg_len;
  logic [CNT_W-1:0] bit_period;
  logic [CNT_W-1:0] guard_period;

  modport master (
    output msg_valid, msg_data, msg_len, bit_period, guard_period,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_data, msg_len, bit_period, guard_period,
    output msg_ready
  );
endinterface

// File: rtl/heater_tx_period_timer.sv
// Loadable down-counter used for both the heating window and the guard gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   load_val   : new count
//   en         : decrement by one (stops at zero)
//   count      : current count
//   last       : count == 1, i.e. this is the final cycle of the interval
module heater_tx_period_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/heater_tx_modulator.sv
// Covert-channel transmitter driving the RO heater bank enable.
// A message accepted over msg_if is sent LSB first. Each bit is a heating
// window of bit_period cycles (heater = bit value), followed by guard_period
// heater-off cycles. tx_done pulses for one cycle after the last bit.
//   clk, rst_n        : clock, asynchronous active-low reset
//   msg_if (slave)    : message handshake, lengths and periods
//   abort             : synchronous cancel in SEND/GUARD/DONE
//   ro_heating_enable : registered heater enable
//   busy              : high in SEND and GUARD
//   bit_index         : index of the bit being sent
//   tx_done           : completion pulse
// Optional build macro: HEATER_TX_MANCHESTER_EN (bit 1 = on then off,
// bit 0 = off then on, within each window).
module heater_tx_modulator
  import heater_tx_pkg::*;
#(
  parameter int unsigned MSG_W = MSG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  heater_tx_modulator_if.slave  msg_if,
  input  logic                  abort,
  output logic                  ro_heating_enable,
  output logic                  busy,
  output logic [LEN_W-1:0]      bit_index,
  output logic                  tx_done
);

  state_t           state;
  logic [MSG_W-1:0] data_r;
  logic [LEN_W-1:0] last_idx_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] guard_r;

  logic             accept;
  logic [CNT_W-1:0] eff_period;
  logic [LEN_W-1:0] eff_len;
  logic             bit_last;
  logic             guard_zero;

  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic [CNT_W-1:0] t_count;
  logic             t_last;

`ifdef HEATER_TX_MANCHESTER_EN
  // Count value on the last cycle of the first half window.
  logic [CNT_W-1:0] half_r;
`else
  logic unused_count_bits;
  assign unused_count_bits = ^t_count;
`endif

  assign msg_if.msg_ready = rst_n && (state == IDLE);
  assign busy             = (state == SEND) || (state == GUARD);
  assign accept           = msg_if.msg_valid && msg_if.msg_ready;
  assign eff_period       = CNT_W'(clamp_period(64'(msg_if.bit_period)));
  assign eff_len          = (msg_if.msg_len > LEN_W'(MSG_W)) ? LEN_W'(MSG_W) : msg_if.msg_len;
  assign bit_last         = (bit_index == last_idx_r);
  assign guard_zero       = (guard_r == '0);

  // One timer serves both windows: it is reloaded on every interval boundary.
  always_comb begin
    t_load = 1'b0;
    t_val  = period_r;
    if (accept) begin
      t_load = 1'b1;
      t_val  = eff_period;
    end else if ((state == SEND) && t_last) begin
      t_load = 1'b1;
      t_val  = guard_zero ? period_r : guard_r;
    end else if ((state == GUARD) && t_last) begin
      t_load = 1'b1;
    end
  end

  heater_tx_period_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (busy),
    .count    (t_count),
    .last     (t_last)
  );

  // data_r shifts right per bit, so the current bit is always data_r[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      data_r            <= '0;
      last_idx_r        <= '0;
      period_r          <= '0;
      guard_r           <= '0;
      bit_index         <= '0;
      ro_heating_enable <= 1'b0;
      tx_done           <= 1'b0;
`ifdef HEATER_TX_MANCHESTER_EN
      half_r            <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          ro_heating_enable <= 1'b0;
          bit_index         <= '0;
          if (accept) begin
            data_r     <= msg_if.msg_data;
            period_r   <= eff_period;
            guard_r    <= msg_if.guard_period;
            last_idx_r <= eff_len - LEN_W'(1);
`ifdef HEATER_TX_MANCHESTER_EN
            half_r     <= eff_period - (eff_period >> 1) + CNT_W'(1);
`endif
            if (eff_len == '0) begin
              state   <= DONE;
              tx_done <= 1'b1;
            end else begin
              state             <= SEND;
              ro_heating_enable <= msg_if.msg_data[0];
            end
          end
        end
        SEND: begin
          if (abort) begin
            state             <= IDLE;
            ro_heating_enable <= 1'b0;
            bit_index         <= '0;
          end else if (t_last) begin
            if (!guard_zero) begin
              state             <= GUARD;
              ro_heating_enable <= 1'b0;
            end else if (bit_last) begin
              state             <= DONE;
              ro_heating_enable <= 1'b0;
              tx_done           <= 1'b1;
            end else begin
              bit_index         <= bit_index + LEN_W'(1);
              data_r            <= data_r >> 1;
              ro_heating_enable <= data_r[1];
            end
          end
`ifdef HEATER_TX_MANCHESTER_EN
          else if (t_count == half_r) begin
            ro_heating_enable <= ~data_r[0];
          end
`endif
        end
        GUARD: begin
          if (abort) begin
            state             <= IDLE;
            ro_heating_enable <= 1'b0;
            bit_index         <= '0;
          end else if (t_last) begin
            if (bit_last) begin
              state   <= DONE;
              tx_done <= 1'b1;
            end else begin
              state             <= SEND;
              bit_index         <= bit_index + LEN_W'(1);
              data_r            <= data_r >> 1;
              ro_heating_enable <= data_r[1];
            end
          end
        end
        DONE: begin
          state             <= IDLE;
          ro_heating_enable <= 1'b0;
          bit_index         <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heater_tx_modulator.sv
// Testbench for heater_tx_modulator: per-cycle expected outputs are queued
// when a message is accepted and compared on every falling clock edge.
module tb_heater_tx_modulator;

  localparam int unsigned MSG_W = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LEN_W = 6;

  typedef struct {
    logic             en;
    logic             done;
    logic             busy;
    logic             ready;
    logic             idx_chk;
    logic [LEN_W-1:0] idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             abort;
  logic             ro_heating_enable;
  logic             busy;
  logic [LEN_W-1:0] bit_index;
  logic             tx_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  exp_t        sb[$];

  heater_tx_modulator_if #(.MSG_W(MSG_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  heater_tx_modulator #(
    .MSG_W (MSG_W),
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .msg_if            (bus),
    .abort             (abort),
    .ro_heating_enable (ro_heating_enable),
    .busy              (busy),
    .bit_index         (bit_index),
    .tx_done           (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of one message, one entry per clock cycle after accept.
  task automatic push_expect(input logic [63:0] data, input int unsigned len,
                             input int unsigned bp, input int unsigned gp);
    int unsigned p;
    int unsigned n;
    exp_t        e;
    p = (bp == 0) ? 1 : bp;
`ifdef HEATER_TX_MANCHESTER_EN
    if (p < 2) p = 2;
`endif
    n = (len > MSG_W) ? MSG_W : len;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned c = 0; c < p; c++) begin
        e.en = data[i];
`ifdef HEATER_TX_MANCHESTER_EN
        e.en = (c < p / 2) ? data[i] : ~data[i];
`endif
        e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
        e.idx_chk = 1'b1; e.idx = LEN_W'(i);
        sb.push_back(e);
      end
      for (int unsigned c = 0; c < gp; c++) begin
        e.en = 1'b0; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
        e.idx_chk = 1'b1; e.idx = LEN_W'(i);
        sb.push_back(e);
      end
    end
    e.en = 1'b0; e.done = 1'b1; e.busy = 1'b0; e.ready = 1'b0;
    e.idx_chk = 1'b0; e.idx = '0;
    sb.push_back(e);
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_msg(input logic [63:0] data, input int unsigned len,
                          input int unsigned bp, input int unsigned gp,
                          input logic with_abort);
    int unsigned waited = 0;
    bus.msg_data     = MSG_W'(data);
    bus.msg_len      = LEN_W'(len);
    bus.bit_period   = CNT_W'(bp);
    bus.guard_period = CNT_W'(gp);
    bus.msg_valid    = 1'b1;
    abort            = with_abort;
    while (!bus.msg_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) check("ready_timeout", 64'(bus.msg_ready), 64'd1);
    @(posedge clk); #1;
    push_expect(data, len, bp, gp);
    bus.msg_valid    = 1'b0;
    abort            = 1'b0;
    // Inputs change while busy; the latched copies must be used.
    bus.msg_data     = ~bus.msg_data;
    bus.msg_len      = LEN_W'(3);
    bus.bit_period   = CNT_W'(9);
    bus.guard_period = CNT_W'(7);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_en",    64'(ro_heating_enable), 64'd0);
      check("rst_ready", 64'(bus.msg_ready),     64'd0);
      check("rst_busy",  64'(busy),              64'd0);
      check("rst_done",  64'(tx_done),           64'd0);
      check("rst_idx",   64'(bit_index),         64'd0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      check("en",    64'(ro_heating_enable), 64'(e.en));
      check("done",  64'(tx_done),           64'(e.done));
      check("busy",  64'(busy),              64'(e.busy));
      check("ready", 64'(bus.msg_ready),     64'(e.ready));
      if (e.idx_chk) check("bit_index", 64'(bit_index), 64'(e.idx));
    end else begin
      check("idle_en",    64'(ro_heating_enable), 64'd0);
      check("idle_done",  64'(tx_done),           64'd0);
      check("idle_busy",  64'(busy),              64'd0);
      check("idle_ready", 64'(bus.msg_ready),     64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    exp_t e;
    // Valid offered throughout reset must not be taken.
    rst_n            = 1'b0;
    abort            = 1'b0;
    bus.msg_valid    = 1'b1;
    bus.msg_data     = MSG_W'(1);
    bus.msg_len      = LEN_W'(1);
    bus.bit_period   = CNT_W'(1);
    bus.guard_period = CNT_W'(0);
    repeat (4) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.msg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send_msg(64'b1011, 4, 5, 3, 1'b0);
    wait_drain(100);

    send_msg(64'hFFFF_FFFF, 0, 7, 2, 1'b0);
    wait_drain(20);

    send_msg(64'hA5C3_0F96, 40, 1, 2, 1'b0);
    wait_drain(200);

    send_msg(64'b10, 2, 0, 0, 1'b0);
    wait_drain(20);

    send_msg(64'b01, 2, 4, 0, 1'b0);
    wait_drain(30);

    // Abort in the guard gap of bit 2 (cycles 22..24 after accept).
    send_msg(64'b1011, 4, 5, 3, 1'b0);
    repeat (21) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    e.en = 1'b0; e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
    e.idx_chk = 1'b1; e.idx = '0;
    sb.push_back(e);
    send_msg(64'b110, 3, 2, 1, 1'b0);
    wait_drain(50);

    // Abort coincident with accept in IDLE is ignored.
    send_msg(64'b10110, 5, 2, 1, 1'b1);
    wait_drain(50);

    // Reset mid-message, then a fresh message.
    send_msg(64'(32'hC3A5_5A3C), 8, 3, 2, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_msg(64'b101, 3, 1, 0, 1'b0);
    wait_drain(30);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/heater_tx_modulator.md
Name: heater_tx_modulator

Overview:
- Covert-channel transmitter stage directly upstream of the RO heater bank; drives its ro_heating_enable input.
- Accepts a message word over a valid/ready handshake and serialises it LSB-first as on-off-keyed heating intervals.
- Each bit is a heating window of programmable length, followed by a programmable heater-off guard gap so the die can cool.
- Done pulse and bit index let software and the sensor side align with the transmission.

Parameters:
- MSG_W, 32, message word width in bits (2..64).
- CNT_W, 32, width of the period counters and period inputs.
- LEN_W, 6, width of msg_len; must satisfy 2^LEN_W > MSG_W.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- msg_valid  input  1  message offered.
- msg_ready  output  1  block can accept; high only in IDLE.
- msg_data  input  MSG_W  payload; bit 0 is sent first.
- msg_len  input  LEN_W  number of bits to send; sampled at accept.
- bit_period  input  CNT_W  heating-window cycles per bit; sampled at accept.
- guard_period  input  CNT_W  heater-off cycles after each bit; sampled at accept.
- abort  input  1  synchronous cancel.
- ro_heating_enable  output  1  registered heater enable to the heater bank.
- busy  output  1  high in SEND and GUARD.
- bit_index  output  LEN_W  index of the bit currently being sent.
- tx_done  output  1  one-cycle pulse when a message completes normally.

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, ro_heating_enable=0, busy=0, bit_index=0, tx_done=0, msg_ready=0. msg_ready rises combinationally from state IDLE once reset is released.
- Accept: msg_valid && msg_ready at a rising edge. Latch msg_data, msg_len, bit_period, guard_period.
  - Effective bit period = max(bit_period, 1).
  - Effective length = min(msg_len, MSG_W).
- If the effective length is 0: go to DONE; ro_heating_enable stays 0.
- Otherwise go to SEND. In the first SEND cycle, ro_heating_enable = data[0] and bit_index = 0.
- SEND: hold ro_heating_enable = data[bit_index] for exactly the effective bit period.
  - At the end of the period, if guard_period > 0: go to GUARD.
  - If guard_period == 0: go to the next bit, or to DONE after the last bit.
- GUARD: ro_heating_enable = 0 for exactly guard_period cycles.
  - Then increment bit_index and return to SEND, or go to DONE if the last bit has been sent.
- DONE: lasts one cycle. tx_done = 1, ro_heating_enable = 0, then go to IDLE.
- Total message cycles = len*(bit_period + guard_period) + 1.
- msg_ready = 1 only in IDLE. Valid is ignored in all other states; the payload is not re-sampled.
- abort is honoured in SEND, GUARD and DONE:
  - Next cycle: state IDLE, ro_heating_enable = 0, bit_index = 0, no tx_done pulse.
  - abort and an accept in the same IDLE cycle: the accept wins and abort is ignored.
- Deasserting rst_n mid-message forces the reset values immediately. No partial state survives reset.
- Counters compare with down-count-to-1. No wrap is possible because the counters reload from the latched period inputs.
- ro_heating_enable is driven directly from a flop with no combinational path, to avoid glitching the heater bank.

Optional Feature:
- Macro: HEATER_TX_MANCHESTER_EN.
- Defined: each SEND window is split into halves. First half = floor(P/2) cycles, second half = P - floor(P/2) cycles.
  - Bit 1 sends on then off; bit 0 sends off then on. This gives constant average heating per bit.
  - An effective period of 1 is raised to 2.
- Undefined: plain on-off keying as described above. No extra logic is synthesised.

Decomposition:
- Package heater_tx_pkg holds:
  - the state enum (IDLE, SEND, GUARD, DONE);
  - the period-clamp helper function;
  - the MSG_W and CNT_W defaults.
- One natural sub-module: heater_tx_period_timer, a loadable down-counter with load, enable and a "last" flag. It is instantiated once and reused for both SEND and GUARD.

Test Plan:
- Reset with msg_valid=1, then release → no accept during reset. msg_ready=1 on the first cycle after release. ro_heating_enable=0 throughout reset.
- data=0b1011, len=4, bit_period=5, guard=3 → enable pattern 5×1,3×0,5×1,3×0,5×0,3×0,5×1,3×0. tx_done pulses at cycle 33 after accept.
- len=0 → tx_done one cycle after accept; enable never rises. len=40 with MSG_W=32 → exactly 32 bits sent.
- bit_period=0, guard=0, data=0b10, len=2 → enable 0 then 1, one cycle each; tx_done on the following cycle.
- abort asserted mid-GUARD of bit 2 → next cycle IDLE, enable=0, bit_index=0, no tx_done. A new message is accepted immediately after.
- With HEATER_TX_MANCHESTER_EN, data=0b01, len=2, bit_period=4, guard=0 → enable 1,1,0,0,0,0,1,1.
